data_mem_access_ctrl: RTL and testbench
=======================================

Name: data_mem_access_ctrl

Overview:
- Sequencer between the EX/MEM pipeline register and the DataMemory block (L1 data cache backed by main memory).
- Accepts one load/store per request, drives DataMemory's address/data/dataRead/dataWrite, samples hit and stalls the pipeline on a read miss while the refill completes.
- Returns load data or a store acknowledge to the MEM/WB stage.
- Keeps hit/miss statistics.

Parameters:
- MISS_PENALTY, 4: cycles spent in REFILL after a read miss before the lookup is retried (legal range 1..255).
- MAX_RETRIES, 2: consecutive missed lookups allowed per read before the request completes with an error (legal range 1..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present; sampled only in IDLE.
- req_read  in  1  load request.
- req_write  in  1  store request.
- req_addr  in  32  byte address; must be word aligned.
- req_wdata  in  32  store data.
- mem_address  out  32  to DataMemory address.
- mem_data  out  32  to DataMemory data.
- mem_read  out  1  to DataMemory dataRead.
- mem_write  out  1  to DataMemory dataWrite.
- mem_out_data  in  32  from DataMemory outData.
- mem_hit  in  1  from DataMemory hit.
- stall  out  1  freezes upstream pipeline registers.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; request failed.
- resp_rdata  out  32  load data, valid with resp_valid on a successful read.
- hit_count  out  16  saturating read-hit counter.
- miss_count  out  16  saturating read-miss counter.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - All outputs 0, including mem_address, mem_data, resp_rdata and both counters.
  - Retry count cleared.
  - An in-flight request is dropped and mem_write falls immediately.
- States: IDLE, ACCESS, REFILL. All outputs are registered or decoded from state only, with no combinational path from req_* to any output.
- IDLE:
  - stall=0; mem_read=mem_write=0.
  - On req_valid with exactly one of req_read/req_write and req_addr[1:0]==0: latch req_addr into mem_address and req_wdata into mem_data, record the operation, clear the retry count, go to ACCESS.
  - On req_valid with a misaligned address, or with both or neither of read/write: stay in IDLE, no memory strobe, resp_valid=1 and resp_err=1 in the next cycle.
- ACCESS:
  - stall=1.
  - Store: mem_write=1 for exactly this one cycle (write-through, no hit dependence); at the next edge go to IDLE with resp_valid=1, resp_err=0.
  - Load: mem_read=1; mem_hit and mem_out_data are sampled at the end of the cycle.
    - Hit: resp_rdata<=mem_out_data, hit_count++, go to IDLE with resp_valid=1.
    - Miss: miss_count++, retry count++. If the retry count reaches MAX_RETRIES, go to IDLE with resp_valid=1, resp_err=1 and resp_rdata unchanged; otherwise go to REFILL.
- REFILL:
  - stall=1; mem_read held at 1; address and data held.
  - Stays exactly MISS_PENALTY cycles (internal down-counter), then returns to ACCESS.
- Latency, measured from the request-accept edge to the cycle with resp_valid high:
  - Store: 2 cycles.
  - Read hit: 2 cycles.
  - Read miss then hit: 3+MISS_PENALTY cycles.
  - stall is high in exactly the cycles the state is not IDLE.
- Back-to-back: resp_valid is high in an IDLE cycle, so a new req_valid in that same cycle is accepted at that edge.
- resp_valid and resp_err are high for exactly one cycle per request. resp_rdata holds its value until the next successful load.
- Counters saturate at 16'hFFFF and never wrap. Stores and errored requests do not count, except that each missed lookup in a read that later errors still increments miss_count.
- req_* inputs are ignored outside IDLE (the pipeline is stalled).

Test Plan:
- Reset, then store addr 0x0000_0010 data 0xDEAD_BEEF -> mem_write high exactly 1 cycle with mem_address=0x10 and mem_data=0xDEADBEEF; resp_valid 2 cycles after accept with resp_err=0; stall high 1 cycle.
- Load 0x10 with mem_hit=1 and mem_out_data=0xDEADBEEF -> resp_rdata=0xDEADBEEF and resp_valid 2 cycles after accept; hit_count=1, miss_count=0.
- Load 0x20 with mem_hit=0 on the first lookup and 1 after refill (MISS_PENALTY=4) -> stall high 6 cycles and mem_read high throughout; resp_valid at cycle 7; miss_count=1, hit_count=1.
- Load with mem_hit stuck at 0 (MAX_RETRIES=2) -> 2 lookups, resp_valid with resp_err=1; miss_count incremented by 2; resp_rdata unchanged.
- Misaligned load at 0x0000_0013, then a request with read=write=1 -> no mem_read/mem_write; each yields resp_valid with resp_err=1 one cycle later; stall stays 0.
- Assert reset during REFILL, then force hit_count to 0xFFFF and do a further hit -> all outputs 0 immediately and state returns to IDLE; after reset releases, a new request is accepted; hit_count remains at 0xFFFF.

Source files
------------

// File: rtl/data_mem_access_ctrl.sv
// Load/store sequencer between the EX/MEM register and the L1 DataMemory block.
// Stalls the pipeline across read-miss refills and keeps saturating hit/miss statistics.
module data_mem_access_ctrl #(
  parameter int unsigned MISS_PENALTY = 4,
  parameter int unsigned MAX_RETRIES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_out_data,
  input  logic        mem_hit,
  output logic        stall,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    REFILL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        op_read_q, op_read_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  retry_q, retry_d;
  logic [7:0]  pen_q, pen_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] hit_q, hit_d;
  logic [15:0] miss_q, miss_d;

  logic req_ok;
  assign req_ok = (req_read ^ req_write) && (req_addr[1:0] == 2'b00);

  always_comb begin
    // NOTE: every next-state signal gets a hold/default value first so no branch can infer a latch.
    state_d      = state_q;
    op_read_d    = op_read_q;
    addr_d       = addr_q;
    data_d       = data_q;
    retry_d      = retry_q;
    pen_d        = pen_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    rdata_d      = rdata_q;
    hit_d        = hit_q;
    miss_d       = miss_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_ok) begin
            addr_d    = req_addr;
            data_d    = req_wdata;
            op_read_d = req_read;
            retry_d   = 3'd0;
            state_d   = ACCESS;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end

      ACCESS: begin
        if (!op_read_q) begin
          // Write-through store: completes regardless of hit.
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end else if (mem_hit) begin
          rdata_d      = mem_out_data;
          hit_d        = (hit_q == 16'hFFFF) ? hit_q : hit_q + 16'd1;
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          miss_d  = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
          retry_d = retry_q + 3'd1;
          if (retry_d == 3'(MAX_RETRIES)) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = IDLE;
          end else begin
            pen_d   = 8'(MISS_PENALTY - 1);
            state_d = REFILL;
          end
        end
      end

      REFILL: begin
        if (pen_q == 8'd0) begin
          state_d = ACCESS;
        end else begin
          pen_d = pen_q - 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_read_q    <= 1'b0;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      retry_q      <= 3'd0;
      pen_q        <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= 32'd0;
      hit_q        <= 16'd0;
      miss_q       <= 16'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
      state_q      <= state_d;
      op_read_q    <= op_read_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      retry_q      <= retry_d;
      pen_q        <= pen_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  // Strobes decode from state and the latched operation only, so reset drops them at once.
  assign stall       = (state_q != IDLE);
  assign mem_read    = op_read_q && ((state_q == ACCESS) || (state_q == REFILL));
  assign mem_write   = !op_read_q && (state_q == ACCESS);
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = rdata_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Self-checking bench for data_mem_access_ctrl: directed plan steps plus random
// transactions scored against a latency/counter model derived from the request rules.
module tb_data_mem_access_ctrl;

  localparam int P    = 4;
  localparam int MAXR = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] mem_address, mem_data, mem_out_data;
  logic        mem_read, mem_write, mem_hit;
  logic        stall, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [15:0] hit_count, miss_count;

  int total = 0;
  int bad   = 0;

  int          exp_hit   = 0;
  int          exp_miss  = 0;
  logic [31:0] exp_rdata = 32'd0;

  data_mem_access_ctrl #(.MISS_PENALTY(P), .MAX_RETRIES(MAXR)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_out_data (mem_out_data),
    .mem_hit      (mem_hit),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat_add(input int base, input int inc);
    return (base + inc > 65535) ? 65535 : base + inc;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the response cycle,
  // so a following call issues its request back-to-back in that same IDLE cycle.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int nmiss, input logic [31:0] rdval);
    int          exp_lat, exp_stall, exp_reads, exp_writes;
    logic        exp_err;
    int          lat, stalls, reads, writes, strobe_bad, budget;
    logic        got_err;
    logic [31:0] got_rdata, hit_data, junk;
    logic [15:0] got_hit, got_miss;
    bit          valid, is_load;

    valid   = (rd ^ wr) && (addr[1:0] == 2'b00);
    is_load = valid && rd;
    if (!valid) begin
      exp_lat = 1; exp_err = 1'b1; exp_stall = 0; exp_reads = 0; exp_writes = 0;
    end else if (!is_load) begin
      exp_lat = 2; exp_err = 1'b0; exp_stall = 1; exp_reads = 0; exp_writes = 1;
    end else if (nmiss < MAXR) begin
      exp_lat = 2 + nmiss * (P + 1); exp_err = 1'b0;
      exp_stall = exp_lat - 1; exp_reads = exp_stall; exp_writes = 0;
    end else begin
      exp_lat = 2 + (MAXR - 1) * (P + 1); exp_err = 1'b1;
      exp_stall = exp_lat - 1; exp_reads = exp_stall; exp_writes = 0;
    end

    req_valid = 1'b1; req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata;
    lat = -1; stalls = 0; reads = 0; writes = 0; strobe_bad = 0;
    got_err = 1'bx; got_rdata = 32'hx; got_hit = 16'hx; got_miss = 16'hx;
    hit_data = 32'd0;
    budget = exp_lat + 2 * (P + 1) + 4;

    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (stall)     stalls++;
      if (mem_read)  reads++;
      if (mem_write) writes++;
      if ((mem_read || mem_write) && ((mem_address !== addr) || (mem_data !== wdata)))
        strobe_bad++;
      if (resp_valid) begin
        lat = c; got_err = resp_err; got_rdata = resp_rdata;
        got_hit = hit_count; got_miss = miss_count;
        req_valid = 1'b0;
        break;
      end
      // While the model says the pipeline is stalled, present junk that must be ignored.
      if (c < exp_lat) begin
        junk = $urandom;
        req_valid = 1'($urandom_range(0, 1));
        req_read = junk[0]; req_write = junk[1]; req_addr = junk; req_wdata = ~junk;
      end else begin
        req_valid = 1'b0;
      end
      if (is_load && ((c - 1) % (P + 1) == 0)) begin
        mem_hit = ((c - 1) / (P + 1)) >= nmiss;
        mem_out_data = mem_hit ? rdval : $urandom;
        if (mem_hit) hit_data = rdval;
      end else begin
        mem_hit = 1'($urandom_range(0, 1));
        mem_out_data = $urandom;
      end
    end

    if (is_load && !exp_err) begin
      exp_hit   = sat_add(exp_hit, 1);
      exp_miss  = sat_add(exp_miss, nmiss);
      exp_rdata = hit_data;
    end else if (is_load) begin
      exp_miss = sat_add(exp_miss, MAXR);
    end

    check("latency",    lat,        exp_lat);
    check("resp_err",   got_err,    exp_err);
    check("resp_rdata", got_rdata,  exp_rdata);
    check("stall_cyc",  stalls,     exp_stall);
    check("read_cyc",   reads,      exp_reads);
    check("write_cyc",  writes,     exp_writes);
    check("strobe_ad",  strobe_bad, 0);
    check("hit_count",  got_hit,    exp_hit);
    check("miss_count", got_miss,   exp_miss);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_stall",  stall,                  0);
      check("idle_resp",   {resp_valid, resp_err}, 0);
      check("idle_strobe", {mem_read, mem_write},  0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {stall, mem_read, mem_write, resp_valid, resp_err}, 0);
    check({tag, "_addr"}, mem_address, 0);
    check({tag, "_data"}, mem_data, 0);
    check({tag, "_rdata"}, resp_rdata, 0);
    check({tag, "_cnt"}, {hit_count, miss_count}, 0);
  endtask

  initial begin
    logic [31:0] a, d;
    int          r;

    reset = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_out_data = 32'd0; mem_hit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Directed plan steps.
    run_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'd0);
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0,        0, 32'hDEAD_BEEF);
    check("load_hit_val", resp_rdata, 32'hDEAD_BEEF);
    run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0,        1, 32'h1234_5678);
    run_txn(1'b1, 1'b0, 32'h0000_0030, 32'h0,        MAXR, 32'hFFFF_0000);
    run_txn(1'b1, 1'b0, 32'h0000_0013, 32'h0,        0, 32'h0);
    run_txn(1'b1, 1'b1, 32'h0000_0040, 32'h5,        0, 32'h0);
    run_txn(1'b0, 1'b0, 32'h0000_0044, 32'h6,        0, 32'h0);
    idle(2);

    // Random transactions mixed with idle gaps and back-to-back issue.
    for (int t = 0; t < 40; t++) begin
      a = $urandom; d = $urandom;
      r = $urandom_range(0, 5);
      case (r)
        0: begin a[1:0] = 2'b00; run_txn(1'b0, 1'b1, a, d, 0, 32'd0); end
        1: begin a[1:0] = 2'b00; run_txn(1'b1, 1'b0, a, d, 0, $urandom); end
        2: begin a[1:0] = 2'b00; run_txn(1'b1, 1'b0, a, d, 1, $urandom); end
        3: begin a[1:0] = 2'b00; run_txn(1'b1, 1'b0, a, d, MAXR, $urandom); end
        4: begin
          if (a[1:0] == 2'b00) a[0] = 1'b1;
          run_txn(d[0], ~d[0], a, d, 0, $urandom);
        end
        default: begin
          a[1:0] = 2'b00;
          run_txn(d[0], d[0], a, d, 0, $urandom);
        end
      endcase
      idle($urandom_range(0, 2));
    end

    // Reset asserted in the middle of a refill.
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    req_addr = 32'h0000_0080; req_wdata = 32'hA5A5_A5A5; mem_hit = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; mem_hit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_read", {stall, mem_read}, 2'b11);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    exp_hit = 0; exp_miss = 0; exp_rdata = 32'd0;
    run_txn(1'b0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 0, 32'd0);
    idle(1);

    // Hit counter saturation.
    force dut.hit_q = 16'hFFFF;
    @(negedge clk);
    release dut.hit_q;
    exp_hit = 65535;
    run_txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 32'h0BAD_CAFE);
    idle(2);
    check("sat_hold", hit_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
